hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have ports rsD and rtD, input, 5 bits each: source register numbers of the instruction in D.
REQ-004 The block SHALL have ports tuseRsD and tuseRtD, input, 2 bits each: cycles until the operand is consumed (0 = D, 1 = E, 2 = M, 3 = unused).
REQ-005 The block SHALL have ports waE, waM and waW, input, 5 bits each: destination register numbers in E/M/W (0 = no write).
REQ-006 The block SHALL have ports tnewE and tnewM, input, 2 bits each: cycles until the producer result is available (0 = available now).
REQ-007 The block SHALL have ports linkE, linkM and linkW, input, 1 bit each: producer result is the stage's pc+8 value.
REQ-008 The block SHALL have port mdStartE, input, 1 bit: multiply/divide instruction in E.
REQ-009 The block SHALL have port mdDivE, input, 1 bit: qualifies mdStartE (1 = divide, 0 = multiply).
REQ-010 The block SHALL have port mdUseD, input, 1 bit: instruction in D is a mult/div/mfhi/mflo/mthi/mtlo.
REQ-011 The block SHALL have ports forwardAD and forwardBD, output, 4 bits each: D-stage operand select (0 = regfile, 1 = pc8E, 2 = ALUoutM, 3 = pc8M, 4 = RegWData, 5 = pc8W).
REQ-012 The block SHALL have ports stallF and stallD, output, 1 bit each: hold PC and the F/D register.
REQ-013 The block SHALL have port flushE, output, 1 bit: insert a bubble into the D/E register.
REQ-014 The block SHALL have port mdBusy, output, 1 bit: the multiply/divide unit is occupied.

Function
REQ-015 forwardAD SHALL be the first match in priority order E, M, W for rsD; a match requires rsD != 0 and rsD equal to that stage's wa.
REQ-016 An E match SHALL give code 1 only if linkE = 1 and tnewE = 0; otherwise it SHALL give code 0 and block any M or W match for that operand.
REQ-017 An M match with tnewM = 0 SHALL give code 3 if linkM = 1, else code 2.
REQ-018 An M match with tnewM != 0 SHALL give code 0 and block any W match for that operand.
REQ-019 A W match SHALL give code 5 if linkW = 1, else code 4.
REQ-020 forwardBD SHALL follow REQ-015 to REQ-019 using rtD.
REQ-021 The data stall SHALL be 1 when, for either operand with tuse != 3 and register != 0, the operand matches waE with tuseX < tnewE, or matches waM with tuseX < tnewM.
REQ-022 The md stall SHALL be 1 when mdUseD = 1 and (mdBusy = 1 or mdStartE = 1).
REQ-023 stallF, stallD and flushE SHALL each equal (data stall OR md stall); these outputs are combinational with no added latency.
REQ-024 The md state machine SHALL have states IDLE and BUSY and a 4-bit down-counter cnt.
REQ-025 In IDLE with mdStartE = 1, the next state SHALL be BUSY, with cnt = 9 if mdDivE = 1, else cnt = 4.
REQ-026 In BUSY, cnt SHALL decrement each cycle; when cnt = 0 the next state SHALL be IDLE, unless mdStartE = 1.
REQ-027 mdStartE = 1 in BUSY SHALL reload cnt per REQ-025 and keep the state BUSY (restart, with no queueing).
REQ-028 mdBusy SHALL be 1 exactly while the state is BUSY; a multiply therefore holds mdBusy for 5 cycles and a divide for 10 cycles, starting the cycle after mdStartE.
REQ-029 mdStartE SHALL be sampled every cycle, including stall cycles; flushE does not cancel an operation already latched.

Reset
REQ-030 When reset = 1 at a rising edge, the state SHALL become IDLE, cnt SHALL become 0 and mdBusy SHALL become 0, even mid-operation; mdStartE is ignored in that cycle.
REQ-031 During reset the forward outputs and the data stall SHALL remain purely combinational from their inputs.
REQ-032 After reset, stallF/stallD/flushE SHALL reflect only the data stall until a new mdStartE is seen.

Verification
REQ-033 rsD=8, tuseRsD=0, waE=8, tnewE=1, linkE=0 -> stallF=stallD=flushE=1, forwardAD=0.
REQ-034 rtD=9, waE=0, waM=9, tnewM=0, linkM=0, waW=9 -> forwardBD=2; with linkM=1 -> forwardBD=3.
REQ-035 rsD=0, waE=waM=waW=0, tuseRsD=0, tnewE=2 -> forwardAD=0, no stall.
REQ-036 mdStartE=1, mdDivE=1 for one cycle, then mdUseD=1 held -> mdBusy=1 for 10 cycles, stall=1 during those cycles, stall=0 in the cycle mdBusy falls.
REQ-037 Multiply started, reset asserted on the 3rd busy cycle -> mdBusy=0 on the next cycle and the md stall is released.
REQ-038 rsD=5, tuseRsD=1, waM=5, tnewM=1, waW=5, linkW=1 -> stall=0 (tuse >= tnew) and forwardAD=0 (the M match blocks the W match).

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard unit.
// master = pipeline side (drives stage info), slave = hazard unit.
interface hazard_ctrl_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [1:0] tuseRsD;
  logic [1:0] tuseRtD;
  logic [4:0] waE;
  logic [4:0] waM;
  logic [4:0] waW;
  logic [1:0] tnewE;
  logic [1:0] tnewM;
  logic       linkE;
  logic       linkM;
  logic       linkW;
  logic       mdStartE;
  logic       mdDivE;
  logic       mdUseD;
  logic [3:0] forwardAD;
  logic [3:0] forwardBD;
  logic       stallF;
  logic       stallD;
  logic       flushE;
  logic       mdBusy;

  modport master (
    output rsD, rtD, tuseRsD, tuseRtD, waE, waM, waW, tnewE, tnewM,
           linkE, linkM, linkW, mdStartE, mdDivE, mdUseD,
    input  forwardAD, forwardBD, stallF, stallD, flushE, mdBusy
  );

  modport slave (
    input  rsD, rtD, tuseRsD, tuseRtD, waE, waM, waW, tnewE, tnewM,
           linkE, linkM, linkW, mdStartE, mdDivE, mdUseD,
    output forwardAD, forwardBD, stallF, stallD, flushE, mdBusy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: D-stage operand forwarding, data/md stalls and
// the multiply/divide occupancy tracker.
module hazard_ctrl (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);
  typedef enum logic {IDLE, BUSY} md_state_t;

  localparam logic [3:0] MUL_LOAD = 4'd4;
  localparam logic [3:0] DIV_LOAD = 4'd9;

  md_state_t  state_reg;
  logic [3:0] cnt_reg;
  logic       md_busy_reg;
  logic       md_stall;
  logic       stall;

  // Operand 0 is rs, operand 1 is rt; both use identical rules.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [4:0] src;
      logic [1:0] tuse;
      logic [3:0] fwd_sel;
      logic       data_stall;

      assign src  = (gi == 0) ? hz.rsD : hz.rtD;
      assign tuse = (gi == 0) ? hz.tuseRsD : hz.tuseRtD;

      // A younger producer that is not ready yet shadows older matches.
      always_comb begin
        fwd_sel = 4'd0;
        if (src != 5'd0 && src == hz.waE) begin
          fwd_sel = (hz.linkE && hz.tnewE == 2'd0) ? 4'd1 : 4'd0;
        end else if (src != 5'd0 && src == hz.waM) begin
          if (hz.tnewM == 2'd0)
            fwd_sel = hz.linkM ? 4'd3 : 4'd2;
        end else if (src != 5'd0 && src == hz.waW) begin
          fwd_sel = hz.linkW ? 4'd5 : 4'd4;
        end
      end

      assign data_stall = (tuse != 2'd3) && (src != 5'd0) &&
                          ((src == hz.waE && tuse < hz.tnewE) ||
                           (src == hz.waM && tuse < hz.tnewM));
    end
  endgenerate

  assign md_stall = hz.mdUseD && (md_busy_reg || hz.mdStartE);
  assign stall    = g_opnd[0].data_stall | g_opnd[1].data_stall | md_stall;

  assign hz.forwardAD = g_opnd[0].fwd_sel;
  assign hz.forwardBD = g_opnd[1].fwd_sel;
  assign hz.stallF    = stall;
  assign hz.stallD    = stall;
  assign hz.flushE    = stall;
  assign hz.mdBusy    = md_busy_reg;

  // A new start in BUSY restarts the count; nothing is queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      md_busy_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hz.mdStartE) begin
            state_reg   <= BUSY;
            cnt_reg     <= hz.mdDivE ? DIV_LOAD : MUL_LOAD;
            md_busy_reg <= 1'b1;
          end
        end
        BUSY: begin
          if (hz.mdStartE) begin
            cnt_reg     <= hz.mdDivE ? DIV_LOAD : MUL_LOAD;
            md_busy_reg <= 1'b1;
          end else if (cnt_reg == 4'd0) begin
            state_reg   <= IDLE;
            md_busy_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          cnt_reg     <= 4'd0;
          md_busy_reg <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed corner cases plus randomized
// stimulus against a behavioural model of forwarding, stalls and md occupancy.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hif)
  );

  int checks = 0;
  int errors = 0;
  int m_rem  = 0;  // model: remaining busy cycles of the md unit

  always @(posedge clk) begin
    if (reset)              m_rem <= 0;
    else if (hif.mdStartE)  m_rem <= hif.mdDivE ? 10 : 5;
    else if (m_rem > 0)     m_rem <= m_rem - 1;
  end

  // Stage s (0=E,1=M,2=W): first match wins; ready gives 2*s+link, else 0.
  function automatic logic [3:0] model_fwd(input logic [4:0] r);
    logic [4:0] wa [3];
    logic [1:0] tn [3];
    logic       lk [3];
    wa = '{hif.waE, hif.waM, hif.waW};
    tn = '{hif.tnewE, hif.tnewM, 2'd0};
    lk = '{hif.linkE, hif.linkM, hif.linkW};
    if (r == 5'd0) return 4'd0;
    for (int s = 0; s < 3; s++)
      if (wa[s] == r) return (tn[s] == 2'd0) ? 4'(2 * s + int'(lk[s])) : 4'd0;
    return 4'd0;
  endfunction

  function automatic logic model_data_stall(input logic [4:0] r, input logic [1:0] tu);
    if (tu == 2'd3 || r == 5'd0) return 1'b0;
    return (r == hif.waE && tu < hif.tnewE) || (r == hif.waM && tu < hif.tnewM);
  endfunction

  function automatic logic model_stall();
    return model_data_stall(hif.rsD, hif.tuseRsD) ||
           model_data_stall(hif.rtD, hif.tuseRtD) ||
           (hif.mdUseD && (m_rem > 0 || hif.mdStartE));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.rsD = 0; hif.rtD = 0; hif.tuseRsD = 3; hif.tuseRtD = 3;
    hif.waE = 0; hif.waM = 0; hif.waW = 0; hif.tnewE = 0; hif.tnewM = 0;
    hif.linkE = 0; hif.linkM = 0; hif.linkW = 0;
    hif.mdStartE = 0; hif.mdDivE = 0; hif.mdUseD = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    hif.mdStartE = 1'b1;  // must be ignored while reset is high
    hif.mdDivE = 1'b1;
    repeat (3) tick();
    // Combinational paths stay live during reset
    hif.rsD = 7; hif.waM = 7; hif.tnewM = 0;
    hif.rtD = 6; hif.tuseRtD = 1; hif.waE = 6; hif.tnewE = 2;
    #1;
    checks++;
    if (hif.forwardAD !== 4'd2) begin
      errors++; $display("FAIL rst_fwdA: got %0d expected 2", hif.forwardAD);
    end
    checks++;
    if (hif.stallF !== 1'b1) begin
      errors++; $display("FAIL rst_data_stall: got %b expected 1", hif.stallF);
    end
    clear_inputs();
    reset = 1'b0;
    hif.mdUseD = 1'b1;
    tick();
    checks++;
    if (hif.mdBusy !== 1'b0) begin
      errors++; $display("FAIL rst_mdBusy: got %b expected 0", hif.mdBusy);
    end
    checks++;
    if (hif.stallD !== 1'b0) begin
      errors++; $display("FAIL rst_stall: got %b expected 0", hif.stallD);
    end
    $display("test_reset done");
  endtask

  task automatic test_forward_directed();
    clear_inputs();
    hif.rsD = 8; hif.tuseRsD = 0; hif.waE = 8; hif.tnewE = 1; hif.linkE = 0;
    #1;
    checks++;
    if ({hif.stallF, hif.stallD, hif.flushE} !== 3'b111 || hif.forwardAD !== 4'd0) begin
      errors++; $display("FAIL e_stall: got stall=%b%b%b fwdA=%0d expected 111 fwdA=0",
                         hif.stallF, hif.stallD, hif.flushE, hif.forwardAD);
    end

    clear_inputs();
    hif.rtD = 9; hif.waE = 0; hif.waM = 9; hif.tnewM = 0; hif.linkM = 0; hif.waW = 9;
    #1;
    checks++;
    if (hif.forwardBD !== 4'd2) begin
      errors++; $display("FAIL m_alu_fwdB: got %0d expected 2", hif.forwardBD);
    end
    hif.linkM = 1;
    #1;
    checks++;
    if (hif.forwardBD !== 4'd3) begin
      errors++; $display("FAIL m_pc8_fwdB: got %0d expected 3", hif.forwardBD);
    end

    clear_inputs();
    hif.rsD = 0; hif.tuseRsD = 0; hif.tnewE = 2;
    #1;
    checks++;
    if (hif.forwardAD !== 4'd0 || hif.stallF !== 1'b0) begin
      errors++; $display("FAIL r0: got fwdA=%0d stall=%b expected 0 0", hif.forwardAD, hif.stallF);
    end

    clear_inputs();
    hif.rsD = 5; hif.tuseRsD = 1; hif.waM = 5; hif.tnewM = 1; hif.waW = 5; hif.linkW = 1;
    #1;
    checks++;
    if (hif.forwardAD !== 4'd0 || hif.stallF !== 1'b0) begin
      errors++; $display("FAIL m_block: got fwdA=%0d stall=%b expected 0 0", hif.forwardAD, hif.stallF);
    end

    clear_inputs();
    hif.rtD = 4; hif.waW = 4; hif.linkW = 1; hif.waE = 4; hif.tnewE = 0; hif.linkE = 1;
    #1;
    checks++;
    if (hif.forwardBD !== 4'd1) begin
      errors++; $display("FAIL e_link_fwdB: got %0d expected 1", hif.forwardBD);
    end
    $display("test_forward_directed done");
  endtask

  task automatic test_md_divide();
    clear_inputs();
    hif.mdStartE = 1; hif.mdDivE = 1;
    tick();
    hif.mdStartE = 0; hif.mdDivE = 0; hif.mdUseD = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (hif.mdBusy !== 1'b1 || hif.stallF !== 1'b1) begin
        errors++; $display("FAIL div_busy[%0d]: got busy=%b stall=%b expected 1 1",
                           i, hif.mdBusy, hif.stallF);
      end
      tick();
    end
    #1;
    checks++;
    if (hif.mdBusy !== 1'b0 || hif.stallF !== 1'b0) begin
      errors++; $display("FAIL div_end: got busy=%b stall=%b expected 0 0", hif.mdBusy, hif.stallF);
    end
    $display("test_md_divide done");
  endtask

  task automatic test_md_reset();
    clear_inputs();
    hif.mdStartE = 1; hif.mdDivE = 0;
    tick();
    hif.mdStartE = 0; hif.mdUseD = 1;
    tick();
    tick();
    checks++;
    if (hif.mdBusy !== 1'b1) begin
      errors++; $display("FAIL mul_busy3: got %b expected 1", hif.mdBusy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (hif.mdBusy !== 1'b0 || hif.flushE !== 1'b0) begin
      errors++; $display("FAIL mul_reset: got busy=%b flush=%b expected 0 0", hif.mdBusy, hif.flushE);
    end
    tick();
    checks++;
    if (hif.mdBusy !== 1'b0 || hif.stallD !== 1'b0) begin
      errors++; $display("FAIL post_reset: got busy=%b stall=%b expected 0 0", hif.mdBusy, hif.stallD);
    end
    $display("test_md_reset done");
  endtask

  task automatic test_back_to_back();
    int n;
    clear_inputs();
    // Plain multiply duration
    hif.mdStartE = 1; hif.mdDivE = 0;
    tick();
    hif.mdStartE = 0;
    n = 0;
    while (hif.mdBusy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL mul_len: got %0d expected 5", n);
    end
    // Multiply restarted as a divide on its 3rd busy cycle
    hif.mdStartE = 1; hif.mdDivE = 0;
    tick();
    hif.mdStartE = 0;
    tick();
    tick();
    hif.mdStartE = 1; hif.mdDivE = 1;
    tick();
    hif.mdStartE = 0; hif.mdDivE = 0;
    n = 0;
    while (hif.mdBusy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL restart_len: got %0d expected 10", n);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_random();
    logic [3:0] exp_a, exp_b;
    logic       exp_s, exp_busy;
    clear_inputs();
    for (int i = 0; i < 300; i++) begin
      tick();
      hif.rsD = 5'($urandom_range(0, 3));
      hif.rtD = 5'($urandom_range(0, 3));
      hif.tuseRsD = 2'($urandom_range(0, 3));
      hif.tuseRtD = 2'($urandom_range(0, 3));
      hif.waE = 5'($urandom_range(0, 3));
      hif.waM = 5'($urandom_range(0, 3));
      hif.waW = 5'($urandom_range(0, 3));
      hif.tnewE = 2'($urandom_range(0, 3));
      hif.tnewM = 2'($urandom_range(0, 3));
      hif.linkE = 1'($urandom_range(0, 1));
      hif.linkM = 1'($urandom_range(0, 1));
      hif.linkW = 1'($urandom_range(0, 1));
      hif.mdStartE = ($urandom_range(0, 11) == 0);
      hif.mdDivE = 1'($urandom_range(0, 1));
      hif.mdUseD = 1'($urandom_range(0, 1));
      #1;
      exp_a = model_fwd(hif.rsD);
      exp_b = model_fwd(hif.rtD);
      exp_s = model_stall();
      exp_busy = (m_rem > 0);
      checks++;
      if (hif.forwardAD !== exp_a) begin
        errors++; $display("FAIL rand_fwdA[%0d]: got %0d expected %0d", i, hif.forwardAD, exp_a);
      end
      checks++;
      if (hif.forwardBD !== exp_b) begin
        errors++; $display("FAIL rand_fwdB[%0d]: got %0d expected %0d", i, hif.forwardBD, exp_b);
      end
      checks++;
      if (hif.stallF !== exp_s || hif.stallD !== exp_s || hif.flushE !== exp_s) begin
        errors++; $display("FAIL rand_stall[%0d]: got %b%b%b expected %b", i,
                           hif.stallF, hif.stallD, hif.flushE, exp_s);
      end
      checks++;
      if (hif.mdBusy !== exp_busy) begin
        errors++; $display("FAIL rand_busy[%0d]: got %b expected %b", i, hif.mdBusy, exp_busy);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_forward_directed();
    test_md_divide();
    test_md_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
